// File: rtl/bayer_mosaic_tx_pkg.sv
// Shared types, Bayer channel selection and colour-bar table for bayer_mosaic_tx.
package bayer_mosaic_tx_pkg;

  typedef enum logic [1:0] {
    BAYER_RGGB = 2'd0,
    BAYER_GRBG = 2'd1,
    BAYER_GBRG = 2'd2,
    BAYER_BGGR = 2'd3
  } bayer_pat_t;

  typedef enum logic [1:0] {
    ST_WAIT_SOF,
    ST_ACTIVE,
    ST_HBL,
    ST_VBL
  } tx_state_t;

  localparam int NUM_BARS = 8;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  // Index 0 is the leftmost bar.
  localparam logic [NUM_BARS-1:0][23:0] COLORBAR_RGB = {
    BAR_BLACK, BAR_BLUE, BAR_RED, BAR_MAGENTA,
    BAR_GREEN, BAR_CYAN, BAR_YELLOW, BAR_WHITE
  };

  function automatic logic [7:0] bayer_pick(input logic [23:0] rgb,
                                            input logic        row_lsb,
                                            input logic        col_lsb,
                                            input bayer_pat_t  pat);
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] pick;
    r = rgb[23:16];
    g = rgb[15:8];
    b = rgb[7:0];
    pick = g;
    case (pat)
      BAYER_RGGB: if ({row_lsb, col_lsb} == 2'b00) pick = r;
                  else if ({row_lsb, col_lsb} == 2'b11) pick = b;
      BAYER_GRBG: if ({row_lsb, col_lsb} == 2'b01) pick = r;
                  else if ({row_lsb, col_lsb} == 2'b10) pick = b;
      BAYER_GBRG: if ({row_lsb, col_lsb} == 2'b01) pick = b;
                  else if ({row_lsb, col_lsb} == 2'b10) pick = r;
      BAYER_BGGR: if ({row_lsb, col_lsb} == 2'b00) pick = b;
                  else if ({row_lsb, col_lsb} == 2'b11) pick = r;
      default:    pick = g;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/bayer_lane_packer.sv
// Collects one raw sample per slot and registers the packed beat when the last slot fills.
module bayer_lane_packer #(
  parameter int LANES  = 2,
  parameter int PIX_W  = 8,
  parameter int SLOT_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [PIX_W-1:0]       in_sample,
  input  logic [SLOT_W-1:0]      in_slot,
  input  logic                   flush,
  output logic [LANES*PIX_W-1:0] data_out,
  output logic                   data_valid
);

  logic [LANES*PIX_W-1:0] fill_q;
  logic [LANES*PIX_W-1:0] fill_d;
  logic                   beat_done;

  assign beat_done = in_valid && (in_slot == SLOT_W'(LANES - 1));

  // A flush discards the partial group; a sample arriving in the same cycle starts the new one.
  always_comb begin
    fill_d = flush ? '0 : fill_q;
    if (in_valid) fill_d[in_slot*PIX_W +: PIX_W] = in_sample;
  end

  // NOTE: the fill register is only a few words, so it is reset with everything else;
  // larger storage would be left unreset and qualified by valid instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q     <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      fill_q     <= beat_done ? '0 : fill_d;
      data_valid <= beat_done;
      if (beat_done) data_out <= fill_d;
    end
  end

endmodule

// File: rtl/bayer_mosaic_tx.sv
// RGB stream to packed raw Bayer beats with line/frame blanking for ISP loopback.
// Optional internal colour-bar source: define BAYER_TX_COLORBAR_EN.
module bayer_mosaic_tx
  import bayer_mosaic_tx_pkg::*;
#(
  parameter int LANES   = 2,
  parameter int PIX_W   = 8,
  parameter int HPIX    = 640,
  parameter int VLINES  = 480,
  parameter int HBLANK  = 16,
  parameter int VBLANK  = 64,
  parameter int PATTERN = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [23:0]            s_rgb,
  input  logic                   s_sof,
  input  logic                   s_eol,
  input  logic                   pat_en,
  output logic [LANES*PIX_W-1:0] data_out,
  output logic                   data_valid,
  output logic                   csi_in_frame,
  output logic [1:0]             err
);

  localparam int COL_W   = (HPIX > 1) ? $clog2(HPIX) : 1;
  localparam int ROW_W   = (VLINES > 1) ? $clog2(VLINES) : 1;
  localparam int BLK_MAX = (HBLANK > VBLANK) ? HBLANK : VBLANK;
  localparam int BLK_W   = $clog2(BLK_MAX + 1);
  localparam int SLOT_W  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam bayer_pat_t PAT = bayer_pat_t'(PATTERN[1:0]);

  tx_state_t        state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic [1:0]       err_q, err_d;
  logic             csi_q, csi_d;
  logic             drop_q, drop_d;
  logic             ready_d;
  logic             bar_q, bar_d;

  logic             in_take;
  logic             gen_take;
  logic             take;
  logic             resync;
  logic             hbl_done;
  logic             vbl_done;
  logic [ROW_W-1:0] eff_row;
  logic [COL_W-1:0] eff_col;
  logic             last_col;
  logic             last_row;
  logic [SLOT_W-1:0] slot;
  logic             group_done;
  logic [23:0]      bar_rgb;
  logic [23:0]      pix_rgb;
  logic [7:0]       chan;
  logic [PIX_W-1:0] sample;

  assign in_take  = s_valid && s_ready &&
                    ((state_q == ST_ACTIVE) || ((state_q == ST_WAIT_SOF) && s_sof));
  assign gen_take = bar_q && ((state_q == ST_ACTIVE) || (state_q == ST_WAIT_SOF));
  assign take     = in_take || gen_take;

  // A start-of-frame anywhere but (0,0) restarts the frame with this very pixel.
  assign resync   = in_take && (state_q == ST_ACTIVE) && s_sof &&
                    ((row_q != '0) || (col_q != '0));
  assign eff_row  = resync ? '0 : row_q;
  assign eff_col  = resync ? '0 : col_q;
  assign last_col = (eff_col == COL_W'(HPIX - 1));
  assign last_row = (eff_row == ROW_W'(VLINES - 1));
  assign slot     = SLOT_W'(32'(eff_col) % LANES);
  assign group_done = take && (slot == SLOT_W'(LANES - 1));

  assign hbl_done = (state_q == ST_HBL) && (blk_q == BLK_W'(HBLANK - 1));
  assign vbl_done = (state_q == ST_VBL) && (blk_q == BLK_W'(VBLANK - 1));

`ifdef BAYER_TX_COLORBAR_EN
  localparam int BAR_W = HPIX / NUM_BARS;

  assign bar_rgb = COLORBAR_RGB[3'(32'(eff_col) / BAR_W)];

  // The source is only switched while idle between frames, never mid-frame.
  always_comb begin
    bar_d = bar_q;
    if (((state_q == ST_WAIT_SOF) && !take) || vbl_done) bar_d = pat_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bar_q <= 1'b0;
    else        bar_q <= bar_d;
  end
`else
  logic pat_en_unused;

  assign pat_en_unused = pat_en;
  assign bar_rgb       = '0;
  assign bar_d         = 1'b0;
  assign bar_q         = 1'b0;
`endif

  assign pix_rgb = gen_take ? bar_rgb : s_rgb;
  assign chan    = bayer_pick(pix_rgb, eff_row[0], eff_col[0], PAT);

  generate
    if (PIX_W >= 8) begin : g_wide
      assign sample = PIX_W'(chan);
    end else begin : g_narrow
      assign sample = chan[7 -: PIX_W];
    end
  endgenerate

  // NOTE: every variable gets its hold value first so no path leaves one unassigned,
  // which is what keeps this block free of latches.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    blk_d   = blk_q;
    err_d   = err_q;
    csi_d   = csi_q;
    drop_d  = 1'b0;

    case (state_q)
      ST_HBL: begin
        blk_d = blk_q + 1'b1;
        if (hbl_done) begin
          state_d = ST_ACTIVE;
          row_d   = row_q + 1'b1;
          blk_d   = '0;
        end
      end
      ST_VBL: begin
        csi_d = 1'b0;
        blk_d = blk_q + 1'b1;
        if (vbl_done) begin
          state_d = ST_WAIT_SOF;
          row_d   = '0;
          blk_d   = '0;
        end
      end
      default: ;
    endcase

    if (take) begin
      state_d = ST_ACTIVE;
      row_d   = eff_row;
      if (last_col) begin
        col_d   = '0;
        blk_d   = '0;
        state_d = last_row ? ST_VBL : ST_HBL;
      end else begin
        col_d = eff_col + 1'b1;
      end
      // The counters stay authoritative; a misplaced s_eol is only reported.
      if (in_take && (s_eol != last_col)) err_d[1] = 1'b1;
    end

    if (resync) begin
      err_d[0] = 1'b1;
      csi_d    = 1'b0;
      drop_d   = csi_q;
    end else if (group_done || drop_q) begin
      csi_d = 1'b1;
    end

    ready_d = ((state_d == ST_WAIT_SOF) || (state_d == ST_ACTIVE)) && !bar_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_WAIT_SOF;
      row_q   <= '0;
      col_q   <= '0;
      blk_q   <= '0;
      err_q   <= '0;
      csi_q   <= 1'b0;
      drop_q  <= 1'b0;
      s_ready <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      blk_q   <= blk_d;
      err_q   <= err_d;
      csi_q   <= csi_d;
      drop_q  <= drop_d;
      s_ready <= ready_d;
    end
  end

  assign csi_in_frame = csi_q;
  assign err          = err_q;

  bayer_lane_packer #(
    .LANES (LANES),
    .PIX_W (PIX_W),
    .SLOT_W(SLOT_W)
  ) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (take),
    .in_sample (sample),
    .in_slot   (slot),
    .flush     (resync),
    .data_out  (data_out),
    .data_valid(data_valid)
  );

endmodule

// File: tb/tb_bayer_mosaic_tx.sv
// Directed self-checking bench for bayer_mosaic_tx (4x2 frames, RGGB and BGGR instances).
module tb_bayer_mosaic_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic [23:0] s_rgb;
  logic        s_sof;
  logic        s_eol;
  logic        pat_en;

  logic        s_ready, data_valid, csi, s_ready_b, data_valid_b, csi_b;
  logic [15:0] data_out, data_out_b;
  logic [1:0]  err, err_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bayer_mosaic_tx #(.LANES(2), .PIX_W(8), .HPIX(4), .VLINES(2), .HBLANK(2), .VBLANK(3),
                    .PATTERN(0)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_rgb(s_rgb),
    .s_sof(s_sof), .s_eol(s_eol), .pat_en(pat_en), .data_out(data_out),
    .data_valid(data_valid), .csi_in_frame(csi), .err(err));

  bayer_mosaic_tx #(.LANES(2), .PIX_W(8), .HPIX(4), .VLINES(2), .HBLANK(2), .VBLANK(3),
                    .PATTERN(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_b), .s_rgb(s_rgb),
    .s_sof(s_sof), .s_eol(s_eol), .pat_en(pat_en), .data_out(data_out_b),
    .data_valid(data_valid_b), .csi_in_frame(csi_b), .err(err_b));

`ifdef BAYER_TX_COLORBAR_EN
  logic        s_valid_c, pat_en_c, s_ready_c, data_valid_c, csi_c;
  logic [15:0] data_out_c;
  logic [1:0]  err_c;
  logic [15:0] bar_beat [8] = '{16'hFFFF, 16'hFFFF, 16'hFF00, 16'hFF00,
                                16'h00FF, 16'h00FF, 16'h0000, 16'h0000};

  bayer_mosaic_tx #(.LANES(2), .PIX_W(8), .HPIX(16), .VLINES(2), .HBLANK(2), .VBLANK(3),
                    .PATTERN(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid_c), .s_ready(s_ready_c), .s_rgb(s_rgb),
    .s_sof(s_sof), .s_eol(s_eol), .pat_en(pat_en_c), .data_out(data_out_c),
    .data_valid(data_valid_c), .csi_in_frame(csi_c), .err(err_c));
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Channels differ per pixel index so channel or lane swaps are visible.
  function automatic logic [23:0] px(input int i);
    return {8'(8'h10 + i), 8'(8'h20 + i), 8'(8'h30 + i)};
  endfunction

  task automatic idle();
    s_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int idx, input logic sof, input logic eol);
    int n;
    n = 0;
    while (!s_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("ready_wait", 32'(s_ready), 32'd1);
    s_valid = 1'b1;
    s_rgb   = px(idx);
    s_sof   = sof;
    s_eol   = eol;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_eol   = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_rgb   = '0;
    s_sof   = 1'b0;
    s_eol   = 1'b0;
    pat_en  = 1'b0;
`ifdef BAYER_TX_COLORBAR_EN
    s_valid_c = 1'b0;
    pat_en_c  = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(s_ready), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_csi", 32'(csi), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;

    // Frame 1: continuous 4x2 frame.
    send(0, 1'b1, 1'b0);
    check("f1_p0_valid", 32'(data_valid), 32'd0);
    check("f1_p0_csi", 32'(csi), 32'd0);
    send(1, 1'b0, 1'b0);
    check("f1_b0_valid", 32'(data_valid), 32'd1);
    check("f1_b0_data", 32'(data_out), 32'h2110);
    check("f1_b0_bggr", 32'(data_out_b), 32'h2130);
    check("f1_b0_valid_b", 32'(data_valid_b), 32'd1);
    check("f1_b0_csi", 32'(csi), 32'd1);
    send(2, 1'b0, 1'b0);
    check("f1_p2_valid", 32'(data_valid), 32'd0);
    send(3, 1'b0, 1'b1);
    check("f1_b1_data", 32'(data_out), 32'h2312);
    check("f1_b1_bggr", 32'(data_out_b), 32'h2332);
    check("f1_hbl_ready", 32'(s_ready), 32'd0);
    send(4, 1'b0, 1'b0);
    check("f1_hbl_csi", 32'(csi), 32'd1);
    check("f1_p4_valid", 32'(data_valid), 32'd0);
    send(5, 1'b0, 1'b0);
    check("f1_b2_valid", 32'(data_valid), 32'd1);
    check("f1_b2_data", 32'(data_out), 32'h3524);
    check("f1_b2_bggr", 32'(data_out_b), 32'h1524);
    send(6, 1'b0, 1'b0);
    send(7, 1'b0, 1'b1);
    check("f1_b3_valid", 32'(data_valid), 32'd1);
    check("f1_b3_data", 32'(data_out), 32'h3726);
    check("f1_b3_bggr", 32'(data_out_b), 32'h1726);
    check("f1_last_csi", 32'(csi), 32'd1);
    idle();
    check("f1_vbl_valid", 32'(data_valid), 32'd0);
    check("f1_vbl_csi", 32'(csi), 32'd0);
    check("f1_vbl_csi_b", 32'(csi_b), 32'd0);
    check("f1_err", 32'(err), 32'd0);

    // Frame 2: discarded pre-SOF pixel, then s_valid 1-0-0-1 inside a group.
    send(9, 1'b0, 1'b0);
    send(0, 1'b1, 1'b0);
    check("tg_p0_valid", 32'(data_valid), 32'd0);
    idle();
    check("tg_gap1_valid", 32'(data_valid), 32'd0);
    idle();
    check("tg_gap2_valid", 32'(data_valid), 32'd0);
    send(1, 1'b0, 1'b0);
    check("tg_beat_valid", 32'(data_valid), 32'd1);
    check("tg_beat_data", 32'(data_out), 32'h2110);
    idle();
    check("tg_single_pulse", 32'(data_valid), 32'd0);
    send(2, 1'b0, 1'b0);
    send(3, 1'b0, 1'b1);
    check("f2_b1_data", 32'(data_out), 32'h2312);
    send(4, 1'b0, 1'b0);
    send(5, 1'b0, 1'b0);
    check("f2_b2_data", 32'(data_out), 32'h3524);

    // SOF at (1,2): resync restarts at (0,0) with this pixel.
    send(8, 1'b1, 1'b0);
    check("rs_err", 32'(err), 32'd1);
    check("rs_csi_drop", 32'(csi), 32'd0);
    check("rs_valid", 32'(data_valid), 32'd0);
    // Early s_eol at column 1.
    send(9, 1'b0, 1'b1);
    check("rs_csi_back", 32'(csi), 32'd1);
    check("rs_b0_valid", 32'(data_valid), 32'd1);
    check("rs_b0_data", 32'(data_out), 32'h2918);
    check("rs_b0_bggr", 32'(data_out_b), 32'h2938);
    check("eol_err", 32'(err), 32'd3);
    check("eol_err_b", 32'(err_b), 32'd3);
    send(10, 1'b0, 1'b0);
    send(11, 1'b0, 1'b1);
    check("eol_b1_valid", 32'(data_valid), 32'd1);
    check("eol_b1_data", 32'(data_out), 32'h2B1A);
    check("eol_b1_bggr", 32'(data_out_b), 32'h2B3A);

    // Reset with a partial group held.
    send(12, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mrst_data", 32'(data_out), 32'd0);
    check("mrst_valid", 32'(data_valid), 32'd0);
    check("mrst_csi", 32'(csi), 32'd0);
    check("mrst_err", 32'(err), 32'd0);
    check("mrst_ready", 32'(s_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(0, 1'b1, 1'b0);
    send(1, 1'b0, 1'b0);
    check("mrst_b0_valid", 32'(data_valid), 32'd1);
    check("mrst_b0_data", 32'(data_out), 32'h2110);
    check("mrst_b0_csi", 32'(csi), 32'd1);

`ifdef BAYER_TX_COLORBAR_EN
    begin
      int n;
      pat_en_c = 1'b1;
      n = 0;
      while (!data_valid_c && n < 20) begin
        @(posedge clk);
        #1;
        n++;
      end
      for (int b = 0; b < 8; b++) begin
        check("cb_valid", 32'(data_valid_c), 32'd1);
        check("cb_data", 32'(data_out_c), 32'(bar_beat[b]));
        check("cb_ready", 32'(s_ready_c), 32'd0);
        idle();
        idle();
      end
      check("cb_err", 32'(err_c), 32'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
